// File: rtl/soc_system_sysid_checker.sv
// Reads the system-ID slave (ID word, optionally build timestamp) and
// compares against the expected build values, reporting pass/fail.
module soc_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'hACD51302,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h58B1E84D,
   parameter bit          CHECK_TIMESTAMP    = 1'b1,
   parameter int unsigned READ_LATENCY       = 0,
   parameter bit          AUTO_START         = 1'b1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        sysid_address,
   output logic        sysid_read,
   input  logic [31:0] sysid_readdata,
   output logic [31:0] id_value,
   output logic [31:0] timestamp_value,
   output logic        busy,
   output logic        done,
   output logic        match,
   output logic        mismatch,
   output logic [7:0]  fail_count
);

   localparam logic [1:0] LAT = READ_LATENCY[1:0];

   typedef enum logic [2:0] {
      IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CHECK
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        auto_q, auto_d;
   logic [31:0] id_q, id_d;
   logic [31:0] ts_q, ts_d;
   logic        read_q, read_d;
   logic        addr_q, addr_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        match_q, match_d;
   logic        mism_q, mism_d;
   logic [7:0]  fail_q, fail_d;
   logic        pass;
   state_t      after_id;

   assign after_id = CHECK_TIMESTAMP ? RD_TS : CHECK;
   assign pass = (id_q == EXPECTED_ID) &&
                 (!CHECK_TIMESTAMP || ts_q == EXPECTED_TIMESTAMP);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      auto_d  = 1'b0;
      id_d    = id_q;
      ts_d    = ts_q;
      done_d  = 1'b0;
      match_d = match_q;
      mism_d  = mism_q;
      fail_d  = fail_q;
      unique case (state_q)
         IDLE: begin
            if (start || auto_q) state_d = RD_ID;
         end
         RD_ID: begin
            if (LAT == 2'd0) begin
               id_d    = sysid_readdata;
               state_d = after_id;
            end else begin
               cnt_d   = LAT - 2'd1;
               state_d = WAIT_ID;
            end
         end
         WAIT_ID: begin
            if (cnt_q == 2'd0) begin
               id_d    = sysid_readdata;
               state_d = after_id;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         RD_TS: begin
            if (LAT == 2'd0) begin
               ts_d    = sysid_readdata;
               state_d = CHECK;
            end else begin
               cnt_d   = LAT - 2'd1;
               state_d = WAIT_TS;
            end
         end
         WAIT_TS: begin
            if (cnt_q == 2'd0) begin
               ts_d    = sysid_readdata;
               state_d = CHECK;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         CHECK: begin
            done_d  = 1'b1;
            match_d = pass;
            mism_d  = !pass;
            if (!pass && fail_q != 8'hFF) fail_d = fail_q + 8'd1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Bus strobes follow the next state so they are registered outputs
      read_d = (state_d == RD_ID) || (state_d == RD_TS);
      addr_d = (state_d == RD_TS);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         auto_q  <= AUTO_START;
         id_q    <= 32'd0;
         ts_q    <= 32'd0;
         read_q  <= 1'b0;
         addr_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         match_q <= 1'b0;
         mism_q  <= 1'b0;
         fail_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         auto_q  <= auto_d;
         id_q    <= id_d;
         ts_q    <= ts_d;
         read_q  <= read_d;
         addr_q  <= addr_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         match_q <= match_d;
         mism_q  <= mism_d;
         fail_q  <= fail_d;
      end
   end

   assign sysid_read      = read_q;
   assign sysid_address   = addr_q;
   assign id_value        = id_q;
   assign timestamp_value = ts_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign match           = match_q;
   assign mismatch        = mism_q;
   assign fail_count      = fail_q;

endmodule

// File: tb/tb_soc_system_sysid_checker.sv
// Three checker instances (default, latency 2, ID-only) against small
// slave models; expected results queued at start and popped on done.
module tb_soc_system_sysid_checker;

   localparam logic [31:0] EID = 32'hACD51302;
   localparam logic [31:0] ETS = 32'h58B1E84D;

   typedef struct {
      logic        m;
      logic [31:0] id;
      logic [31:0] ts;
      logic [7:0]  fc;
      int          cyc;
   } exp_t;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];

   logic rst_a = 1'b0, rst_b = 1'b0, rst_c = 1'b0;
   logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
   logic [31:0] a_id = EID, a_ts = ETS, c_id = EID;

   logic addr_a, read_a, busy_a, done_a, match_a, mism_a;
   logic addr_b, read_b, busy_b, done_b, match_b, mism_b;
   logic addr_c, read_c, busy_c, done_c, match_c, mism_c;
   logic [31:0] rd_a, rd_b, rd_c, id_a, id_b, id_c, ts_a, ts_b, ts_c;
   logic [7:0] fc_a, fc_b, fc_c;
   logic [1:0] b_p1 = 2'b00, b_p2 = 2'b00;

   int a_n0 = 0, a_n1 = 0, c_n0 = 0, c_n1 = 0;

   assign rd_a = !read_a ? 32'hDEADBEEF : (addr_a ? a_ts : a_id);
   assign rd_c = !read_c ? 32'hDEADBEEF : (addr_c ? 32'h0BADF00D : c_id);
   always @(posedge clock) begin
      b_p1 <= {read_b, addr_b};
      b_p2 <= b_p1;
   end
   assign rd_b = !b_p2[1] ? 32'hDEADBEEF : (b_p2[0] ? 32'h0 : EID);

   soc_system_sysid_checker u_a (
      .clock(clock), .reset_n(rst_a), .start(start_a),
      .sysid_address(addr_a), .sysid_read(read_a),
      .sysid_readdata(rd_a), .id_value(id_a),
      .timestamp_value(ts_a), .busy(busy_a), .done(done_a),
      .match(match_a), .mismatch(mism_a), .fail_count(fc_a));

   soc_system_sysid_checker #(.READ_LATENCY(2)) u_b (
      .clock(clock), .reset_n(rst_b), .start(start_b),
      .sysid_address(addr_b), .sysid_read(read_b),
      .sysid_readdata(rd_b), .id_value(id_b),
      .timestamp_value(ts_b), .busy(busy_b), .done(done_b),
      .match(match_b), .mismatch(mism_b), .fail_count(fc_b));

   soc_system_sysid_checker #(
      .CHECK_TIMESTAMP(1'b0), .AUTO_START(1'b0)) u_c (
      .clock(clock), .reset_n(rst_c), .start(start_c),
      .sysid_address(addr_c), .sysid_read(read_c),
      .sysid_readdata(rd_c), .id_value(id_c),
      .timestamp_value(ts_c), .busy(busy_c), .done(done_c),
      .match(match_c), .mismatch(mism_c), .fail_count(fc_c));

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmp_done(input string p, input exp_t e,
                           input logic m, input logic mm,
                           input logic [31:0] id, input logic [31:0] ts,
                           input logic [7:0] fc);
      check({p, "_match"}, 32'(m), 32'(e.m));
      check({p, "_mismatch"}, 32'(mm), 32'(!e.m));
      check({p, "_id"}, id, e.id);
      check({p, "_ts"}, ts, e.ts);
      check({p, "_failcnt"}, 32'(fc), 32'(e.fc));
      check({p, "_latency"}, 32'(cyc), 32'(e.cyc));
   endtask

   always @(negedge clock) begin
      exp_t e;
      check("a_excl", 32'(match_a & mism_a), 32'd0);
      check("a_addr", 32'(addr_a & ~read_a), 32'd0);
      if (read_a) begin
         if (addr_a) a_n1++;
         else a_n0++;
      end
      if (done_a) begin
         check("a_done_expected", 32'(qa.size() != 0), 32'd1);
         if (qa.size() != 0) begin
            e = qa.pop_front();
            cmp_done("a", e, match_a, mism_a, id_a, ts_a, fc_a);
         end
      end
   end

   always @(negedge clock) begin
      exp_t e;
      check("b_excl", 32'(match_b & mism_b), 32'd0);
      check("b_addr", 32'(addr_b & ~read_b), 32'd0);
      if (done_b) begin
         check("b_done_expected", 32'(qb.size() != 0), 32'd1);
         if (qb.size() != 0) begin
            e = qb.pop_front();
            cmp_done("b", e, match_b, mism_b, id_b, ts_b, fc_b);
         end
      end
   end

   always @(negedge clock) begin
      exp_t e;
      check("c_excl", 32'(match_c & mism_c), 32'd0);
      check("c_addr", 32'(addr_c & ~read_c), 32'd0);
      if (read_c) begin
         if (addr_c) c_n1++;
         else c_n0++;
      end
      if (done_c) begin
         check("c_done_expected", 32'(qc.size() != 0), 32'd1);
         if (qc.size() != 0) begin
            e = qc.pop_front();
            cmp_done("c", e, match_c, mism_c, id_c, ts_c, fc_c);
         end
      end
   end

   function automatic int qsize(input int w);
      case (w)
         0: return qa.size();
         1: return qb.size();
         default: return qc.size();
      endcase
   endfunction

   task automatic wait_q(input int w, input string tag);
      int n = 0;
      while (qsize(w) != 0 && n < 200) begin
         @(negedge clock);
         n++;
      end
      check({tag, "_timeout"}, 32'(qsize(w)), 32'd0);
      @(negedge clock);
      #1;
   endtask

   function automatic exp_t mk(input logic m, input logic [31:0] id,
                               input logic [31:0] ts,
                               input logic [7:0] fc, input int c);
      exp_t e;
      e.m = m; e.id = id; e.ts = ts; e.fc = fc; e.cyc = c;
      return e;
   endfunction

   initial begin
      int base;
      int n0;
      int n1;
      repeat (2) @(negedge clock);
      check("rst_a_busy", 32'(busy_a), 32'd0);
      check("rst_a_read", 32'(read_a), 32'd0);
      check("rst_a_id", id_a, 32'd0);
      check("rst_a_flags", 32'({done_a, match_a, mism_a}), 32'd0);
      check("rst_b_fc", 32'(fc_b), 32'd0);
      check("rst_c_ts", ts_c, 32'd0);

      // release: A and B auto-start, C waits for start
      @(negedge clock);
      rst_a = 1'b1;
      rst_b = 1'b1;
      rst_c = 1'b1;
      qa.push_back(mk(1'b1, EID, ETS, 8'd0, cyc + 4));
      qb.push_back(mk(1'b0, EID, 32'd0, 8'd1, cyc + 8));
      wait_q(0, "a_auto");
      wait_q(1, "b_auto");
      check("a_auto_rd0", 32'(a_n0), 32'd1);
      check("a_auto_rd1", 32'(a_n1), 32'd1);
      check("c_no_auto", 32'(c_n0 + c_n1), 32'd0);

      @(negedge clock);
      start_a = 1'b1;
      qa.push_back(mk(1'b1, EID, ETS, 8'd0, cyc + 4));
      @(negedge clock);
      start_a = 1'b0;
      wait_q(0, "a_start");

      @(negedge clock);
      a_id = 32'h12345678;
      start_a = 1'b1;
      qa.push_back(mk(1'b0, 32'h12345678, ETS, 8'd1, cyc + 4));
      @(negedge clock);
      start_a = 1'b0;
      wait_q(0, "a_bad_id");
      a_id = EID;

      // start held high: back-to-back checks, extra starts ignored
      n0 = a_n0;
      n1 = a_n1;
      @(negedge clock);
      base = cyc;
      start_a = 1'b1;
      qa.push_back(mk(1'b1, EID, ETS, 8'd1, base + 4));
      qa.push_back(mk(1'b1, EID, ETS, 8'd1, base + 8));
      qa.push_back(mk(1'b1, EID, ETS, 8'd1, base + 12));
      repeat (2) @(negedge clock);
      check("a_hold_mismatch", 32'({match_a, mism_a}), 32'd1);
      repeat (10) @(negedge clock);
      start_a = 1'b0;
      wait_q(0, "a_burst");
      check("a_burst_rd0", 32'(a_n0 - n0), 32'd3);
      check("a_burst_rd1", 32'(a_n1 - n1), 32'd3);

      @(negedge clock);
      start_b = 1'b1;
      qb.push_back(mk(1'b0, EID, 32'd0, 8'd2, cyc + 8));
      @(negedge clock);
      start_b = 1'b0;
      wait_q(1, "b_start");

      // reset while waiting on the timestamp word
      @(negedge clock);
      start_b = 1'b1;
      @(negedge clock);
      start_b = 1'b0;
      repeat (4) @(negedge clock);
      check("b_mid_busy", 32'(busy_b), 32'd1);
      rst_b = 1'b0;
      #1;
      check("b_rst_bus", 32'({read_b, addr_b}), 32'd0);
      check("b_rst_data", id_b | ts_b, 32'd0);
      check("b_rst_flags",
            32'({busy_b, done_b, match_b, mism_b}), 32'd0);
      check("b_rst_fc", 32'(fc_b), 32'd0);
      @(negedge clock);
      rst_b = 1'b1;
      qb.push_back(mk(1'b0, EID, 32'd0, 8'd1, cyc + 8));
      wait_q(1, "b_restart");

      @(negedge clock);
      start_c = 1'b1;
      qc.push_back(mk(1'b1, EID, 32'd0, 8'd0, cyc + 3));
      @(negedge clock);
      start_c = 1'b0;
      wait_q(2, "c_start");
      check("c_rd0", 32'(c_n0), 32'd1);
      check("c_rd1", 32'(c_n1), 32'd0);

      c_id = 32'hFFFF0000;
      for (int i = 1; i <= 300; i++) begin
         @(negedge clock);
         start_c = 1'b1;
         qc.push_back(mk(1'b0, 32'hFFFF0000, 32'd0,
                         (i > 255) ? 8'hFF : 8'(i), cyc + 3));
         @(negedge clock);
         start_c = 1'b0;
         wait_q(2, "c_sat");
      end
      check("c_fc_final", 32'(fc_c), 32'h0000_00FF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/soc_system_sysid_checker.md
SOC_SYSTEM_SYSID_CHECKER -- requirements
Module: soc_system_sysid_checker

Interface
REQ-001 Parameter EXPECTED_ID, default 32'hACD51302, system ID value required at word 0.
REQ-002 Parameter EXPECTED_TIMESTAMP, default 32'h58B1E84D, build timestamp value required at word 1.
REQ-003 Parameter CHECK_TIMESTAMP, default 1: 1 compares both words, 0 compares word 0 only.
REQ-004 Parameter READ_LATENCY, default 0, range 0..3: cycles from read strobe to valid readdata.
REQ-005 Parameter AUTO_START, default 1: 1 starts one check automatically after reset release.
REQ-006 clock  input  1  single clock; all logic on rising edge.
REQ-007 reset_n  input  1  asynchronous, active-low reset.
REQ-008 start  input  1  one-cycle request to run a check.
REQ-009 sysid_address  output  1  word select to the system-ID slave (0 = ID, 1 = timestamp).
REQ-010 sysid_read  output  1  read strobe, one cycle per word.
REQ-011 sysid_readdata  input  32  data returned by the system-ID slave.
REQ-012 id_value  output  32  last captured word 0.
REQ-013 timestamp_value  output  32  last captured word 1.
REQ-014 busy  output  1  high while a check is in progress.
REQ-015 done  output  1  one-cycle pulse at check completion.
REQ-016 match  output  1  result of last completed check passed; held until next completion.
REQ-017 mismatch  output  1  result of last completed check failed; held until next completion.
REQ-018 fail_count  output  8  saturating count of failed checks since reset.

Function
REQ-019 FSM states IDLE, RD_ID, WAIT_ID, RD_TS, WAIT_TS, CHECK; all outputs registered.
REQ-020 IDLE -> RD_ID when start=1 sampled in IDLE, or on first edge after reset release when AUTO_START=1.
REQ-021 RD_ID: sysid_read=1, sysid_address=0 for exactly one cycle; then WAIT_ID.
REQ-022 WAIT_ID: lasts READ_LATENCY cycles (zero cycles when 0); sysid_readdata captured into id_value READ_LATENCY cycles after the RD_ID cycle (same cycle when 0).
REQ-023 After capture of word 0: CHECK_TIMESTAMP=1 -> RD_TS; CHECK_TIMESTAMP=0 -> CHECK, timestamp_value unchanged.
REQ-024 RD_TS/WAIT_TS: identical to RD_ID/WAIT_ID with sysid_address=1, capture into timestamp_value.
REQ-025 sysid_address SHALL be 0 whenever sysid_read=0; sysid_read never high outside RD_ID/RD_TS.
REQ-026 CHECK: one cycle; pass = (id_value==EXPECTED_ID) and (CHECK_TIMESTAMP=0 or timestamp_value==EXPECTED_TIMESTAMP); at end of CHECK register done=1, match=pass, mismatch=!pass; return to IDLE.
REQ-027 done high exactly one cycle (first IDLE cycle after CHECK); match and mismatch never both 1.
REQ-028 fail_count increments by 1 on each failed check; holds at 8'hFF (no wrap).
REQ-029 busy=1 in every state except IDLE.
REQ-030 start while busy=1 SHALL be ignored, not queued.
REQ-031 start sampled in the same cycle done=1 (IDLE) SHALL begin a new check; match/mismatch hold prior result until that check completes.
REQ-032 Total latency start-sampled to done: 4+2*READ_LATENCY cycles with CHECK_TIMESTAMP=1, 3+READ_LATENCY with CHECK_TIMESTAMP=0.

Reset
REQ-033 reset_n=0 asynchronously forces IDLE, sysid_read=0, sysid_address=0, id_value=0, timestamp_value=0, busy=0, done=0, match=0, mismatch=0, fail_count=0, including mid-check.
REQ-034 Reset during RD_ID/WAIT_*/CHECK SHALL discard the partial check; no done pulse and no fail_count change for it.
REQ-035 AUTO_START trigger fires once per reset release only.

Verification
REQ-036 Defaults, slave returns 32'hACD51302/32'h58B1E84D -> reads addr 0 then 1, done pulse 4 cycles after start, match=1, fail_count=0.
REQ-037 READ_LATENCY=2, word 1 returns 32'h00000000 -> done 8 cycles after start, mismatch=1, timestamp_value=0, fail_count=1.
REQ-038 CHECK_TIMESTAMP=0, word 0 correct -> single read at addr 0, done 3 cycles after start, match=1, timestamp_value=0.
REQ-039 start pulsed every cycle during a check -> exactly one done per completed check, no extra sysid_read strobes.
REQ-040 reset_n asserted in WAIT_TS -> all outputs zero same cycle; AUTO_START=1 restarts a full check after release.
REQ-041 300 consecutive failing checks -> fail_count stops at 8'hFF.
